// File: rtl/inst_loader_pkg.sv
// Shared types for the boot-time instruction loader.
// The CSUM state exists only in builds with LOADER_CHECKSUM_EN defined.
package inst_loader_pkg;

   typedef logic [31:0] inst_t;
   typedef logic [31:0] addr_t;
   typedef logic [15:0] word_count_t;

   typedef enum logic [2:0] {
      ST_HDR_HI = 3'd0,
      ST_HDR_LO = 3'd1,
      ST_WORD   = 3'd2,
      ST_WRITE  = 3'd3,
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM   = 3'd4,
`endif
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } loader_state_t;

   // States in which a stream byte may be taken.
   function automatic logic loader_accepts(input loader_state_t s);
      logic w_acc;
      w_acc = (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_WORD);
`ifdef LOADER_CHECKSUM_EN
      w_acc = w_acc || (s == ST_CSUM);
`endif
      return w_acc;
   endfunction

endpackage

// File: rtl/inst_loader_word_asm.sv
// Big-endian byte-to-word assembler: three held bytes plus the incoming one form the word.
// Combinational output, index advances on every shift; no backpressure of its own.
module inst_loader_word_asm
   import inst_loader_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_shift,
   input  logic [7:0] i_byte,
   output inst_t      o_word,
   output logic       o_last
);

   logic [23:0] r_word;
   logic [1:0]  r_idx;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_word <= '0;
         r_idx  <= '0;
      end else if (i_shift) begin
         r_word <= {r_word[15:0], i_byte};
         r_idx  <= r_idx + 2'd1;
      end
   end

   // First byte of a word ends up in [31:24] once three more have shifted in.
   assign o_word = {r_word, i_byte};
   assign o_last = (r_idx == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Boot loader: header count, big-endian words, one load strobe per word; optional XOR trailer (LOADER_CHECKSUM_EN).
// load one cycle after a word's 4th byte (5 cycles/word at full rate); in_ready low in WRITE/DONE/ERR.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter addr_t       BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_in_valid,
   input  logic [7:0] i_in_data,
   output logic       o_in_ready,
   output logic       o_load,
   output addr_t      o_load_addr,
   output inst_t      o_load_inst,
   output logic       o_cpu_hold,
   output logic       o_done,
   output logic       o_error
);

   localparam word_count_t LP_MAX = word_count_t'(MAX_WORDS);

   loader_state_t r_state;
   logic [7:0]    r_count_hi;
   word_count_t   r_remaining;
   addr_t         r_addr;
   logic          r_load;
   inst_t         r_load_inst;
   logic          r_hold;
   logic          r_done;
   logic          r_error;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]    r_xor;
`endif

   logic          w_accept;
   logic          w_shift;
   word_count_t   w_count;
   inst_t         w_word;
   logic          w_last;

   assign o_in_ready = !i_rst && loader_accepts(r_state);
   assign w_accept   = i_in_valid && o_in_ready;
   assign w_shift    = w_accept && (r_state == ST_WORD);
   assign w_count    = {r_count_hi, i_in_data};

   inst_loader_word_asm u_asm (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_shift (w_shift),
      .i_byte  (i_in_data),
      .o_word  (w_word),
      .o_last  (w_last)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_HDR_HI;
         r_count_hi  <= '0;
         r_remaining <= '0;
         r_addr      <= BASE_ADDR;
         r_load      <= 1'b0;
         r_load_inst <= '0;
         r_hold      <= 1'b1;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         r_xor       <= '0;
`endif
      end else begin
         r_load <= 1'b0;
         case (r_state)
            ST_HDR_HI: begin
               if (w_accept) begin
                  r_count_hi <= i_in_data;
                  r_state    <= ST_HDR_LO;
               end
            end
            ST_HDR_LO: begin
               if (w_accept) begin
                  if (w_count > LP_MAX) begin
                     r_state <= ST_ERR;
                     r_error <= 1'b1;
                  end else if (w_count == '0) begin
`ifdef LOADER_CHECKSUM_EN
                     r_state <= ST_CSUM;
`else
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                     r_hold  <= 1'b0;
`endif
                  end else begin
                     r_remaining <= w_count;
                     r_state     <= ST_WORD;
                  end
               end
            end
            ST_WORD: begin
               if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
                  r_xor <= r_xor ^ i_in_data;
`endif
                  if (w_last) begin
                     r_load      <= 1'b1;
                     r_load_inst <= w_word;
                     r_state     <= ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               r_addr      <= r_addr + 32'd4;
               r_remaining <= r_remaining - 16'd1;
               if (r_remaining == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                  r_state <= ST_CSUM;
`else
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_hold  <= 1'b0;
`endif
               end else begin
                  r_state <= ST_WORD;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (w_accept) begin
                  if (i_in_data == r_xor) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                     r_hold  <= 1'b0;
                  end else begin
                     r_state <= ST_ERR;
                     r_error <= 1'b1;
                  end
               end
            end
`endif
            ST_DONE: r_state <= ST_DONE;
            ST_ERR:  r_state <= ST_ERR;
            default: begin
               r_state <= ST_ERR;
               r_error <= 1'b1;
            end
         endcase
      end
   end

   assign o_load      = r_load;
   assign o_load_addr = r_addr;
   assign o_load_inst = r_load_inst;
   assign o_cpu_hold  = r_hold;
   assign o_done      = r_done;
   assign o_error     = r_error;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: cycle table for a full-rate 2-word image plus corner-case sequences.
module tb_inst_loader;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_in_valid;
   logic [7:0]  i_in_data;
   logic        o_in_ready;
   logic        o_load;
   logic [31:0] o_load_addr;
   logic [31:0] o_load_inst;
   logic        o_cpu_hold;
   logic        o_done;
   logic        o_error;

   always #5 clk = ~clk;

   inst_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_in_valid  (i_in_valid),
      .i_in_data   (i_in_data),
      .o_in_ready  (o_in_ready),
      .o_load      (o_load),
      .o_load_addr (o_load_addr),
      .o_load_inst (o_load_inst),
      .o_cpu_hold  (o_cpu_hold),
      .o_done      (o_done),
      .o_error     (o_error)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int rule_viol = 0;
   bit rule_en = 0;

   // Write monitor: records every load pulse and counts back-to-back pulses.
   logic [31:0] mon_addr[$];
   logic [31:0] mon_inst[$];
   int  n_loads = 0;
   int  n_dup   = 0;
   bit  prev_load = 0;
   always @(negedge clk) begin
      if (!i_rst && o_load) begin
         mon_addr.push_back(o_load_addr);
         mon_inst.push_back(o_load_inst);
         n_loads++;
         if (prev_load) n_dup++;
      end
      prev_load = o_load;
   end

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired", name);
   endtask

   task automatic rule_check();
      if (rule_en && !o_done && !o_error && (o_in_ready !== !o_load)) rule_viol++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_in_valid = 1'b0;
      i_in_data = 8'h00;
      tick();
      i_rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      bit got;
      got = 0;
      i_in_valid = 1'b1;
      i_in_data  = b;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         rule_check();
         if (o_in_ready) got = 1;
         tick();
      end
      i_in_valid = 1'b0;
      if (!got) fail_now("send_byte");
      if (gap) begin
         @(negedge clk);
         rule_check();
         tick();
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      logic [31:0] v;
      v = w;
      send_byte(v[31:24], gap);
      send_byte(v[23:16], gap);
      send_byte(v[15:8], gap);
      send_byte(v[7:0], gap);
   endtask

   task automatic wait_end(input string name);
      bit seen;
      seen = 0;
      for (int t = 0; t < 50 && !seen; t++) begin
         @(negedge clk);
         rule_check();
         if (o_done || o_error) seen = 1;
         else tick();
      end
      if (!seen) fail_now(name);
   endtask

   // Cycle table record: inputs for the cycle and the outputs expected in it.
   // flags = {in_ready, load, done, error, cpu_hold}
   typedef struct {
      logic        rst;
      logic        vld;
      logic [7:0]  dat;
      logic [4:0]  flags;
      logic [31:0] addr;
      logic        chk_inst;
      logic [31:0] inst;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                               input logic [4:0] f, input logic [31:0] a,
                               input logic ci, input logic [31:0] ins);
      vec_t x;
      x.rst = r; x.vld = v; x.dat = d; x.flags = f;
      x.addr = a; x.chk_inst = ci; x.inst = ins;
      return x;
   endfunction

   initial begin
      int base;
      vec_t cv;
      logic [71:0] act;
      logic [71:0] exp;

      vecs.push_back(mk(1, 0, 8'h00, 5'b00001, 32'h0, 1, 32'h0));
      vecs.push_back(mk(0, 1, 8'h00, 5'b10001, 32'h0, 0, 32'h0));
      vecs.push_back(mk(0, 1, 8'h02, 5'b10001, 32'h0, 0, 32'h0));
      vecs.push_back(mk(0, 1, 8'h20, 5'b10001, 32'h0, 0, 32'h0));
      vecs.push_back(mk(0, 1, 8'h08, 5'b10001, 32'h0, 0, 32'h0));
      vecs.push_back(mk(0, 1, 8'h00, 5'b10001, 32'h0, 0, 32'h0));
      vecs.push_back(mk(0, 1, 8'h05, 5'b10001, 32'h0, 0, 32'h0));
      vecs.push_back(mk(0, 1, 8'hFF, 5'b01001, 32'h0, 1, 32'h2008_0005));
      vecs.push_back(mk(0, 1, 8'h00, 5'b10001, 32'h4, 0, 32'h0));
      vecs.push_back(mk(0, 1, 8'h00, 5'b10001, 32'h4, 0, 32'h0));
      vecs.push_back(mk(0, 1, 8'h00, 5'b10001, 32'h4, 0, 32'h0));
      vecs.push_back(mk(0, 1, 8'h0C, 5'b10001, 32'h4, 0, 32'h0));
      vecs.push_back(mk(0, 0, 8'h00, 5'b01001, 32'h4, 1, 32'h0000_000C));
`ifdef LOADER_CHECKSUM_EN
      vecs.push_back(mk(0, 1, 8'h21, 5'b10001, 32'h8, 0, 32'h0));
`endif
      vecs.push_back(mk(0, 1, 8'h77, 5'b00100, 32'h8, 0, 32'h0));
      vecs.push_back(mk(0, 0, 8'h00, 5'b00100, 32'h8, 0, 32'h0));

      i_rst = 1'b1;
      i_in_valid = 1'b0;
      i_in_data = 8'h00;
      tick();
      tick();

      // Full-rate N=2 image, checked every cycle.
      base = n_loads;
      for (int i = 0; i < vecs.size(); i++) begin
         cv = vecs[i];
         i_rst = cv.rst;
         i_in_valid = cv.vld;
         i_in_data = cv.dat;
         @(negedge clk);
         act = {3'b0, o_in_ready, o_load, o_done, o_error, o_cpu_hold, o_load_addr,
                cv.chk_inst ? o_load_inst : 32'h0};
         exp = {3'b0, cv.flags, cv.addr, cv.chk_inst ? cv.inst : 32'h0};
         check($sformatf("vec%0d", i), act, exp);
         tick();
      end
      check("fullrate_loads", 72'(n_loads - base), 72'd2);

      // Same image, in_valid toggling.
      do_reset();
      base = n_loads;
      rule_viol = 0;
      rule_en = 1;
      send_byte(8'h00, 1);
      send_byte(8'h02, 1);
      send_word(32'h2008_0005, 1);
      send_word(32'h0000_000C, 1);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h21, 1);
`endif
      wait_end("toggle_end");
      rule_en = 0;
      check("toggle_nloads", 72'(n_loads - base), 72'd2);
      if (n_loads - base >= 2) begin
         check("toggle_w0", {8'h0, mon_addr[base], mon_inst[base]}, {8'h0, 32'h0, 32'h2008_0005});
         check("toggle_w1", {8'h0, mon_addr[base+1], mon_inst[base+1]}, {8'h0, 32'h4, 32'h0000_000C});
      end
      check("toggle_done_hold_err", {69'h0, o_done, o_cpu_hold, o_error}, {69'h0, 3'b100});
      check("toggle_ready_rule", 72'(rule_viol), 72'd0);
      check("no_double_pulse", 72'(n_dup), 72'd0);

      // Count just above MAX_WORDS.
      do_reset();
      base = n_loads;
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      @(negedge clk);
      check("ovf_err_next", {69'h0, o_error, o_cpu_hold, o_done}, {69'h0, 3'b110});
      i_in_valid = 1'b1;
      i_in_data = 8'h12;
      for (int t = 0; t < 6; t++) begin
         tick();
         @(negedge clk);
      end
      check("ovf_ready_low", {71'h0, o_in_ready}, 72'h0);
      check("ovf_sticky", {70'h0, o_error, o_cpu_hold}, {70'h0, 2'b11});
      check("ovf_no_load", 72'(n_loads - base), 72'd0);
      i_in_valid = 1'b0;

      // Count exactly MAX_WORDS is accepted.
      do_reset();
      send_byte(8'h04, 0);
      send_byte(8'h00, 0);
      @(negedge clk);
      check("max_ok", {70'h0, o_error, o_in_ready}, {70'h0, 2'b01});

      // Empty image.
      do_reset();
      base = n_loads;
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
      @(negedge clk);
      check("zero_wait_csum", {70'h0, o_done, o_in_ready}, {70'h0, 2'b01});
      tick();
      send_byte(8'h00, 0);
`endif
      @(negedge clk);
      check("zero_done", {69'h0, o_done, o_cpu_hold, o_error}, {69'h0, 3'b100});
      check("zero_no_load", 72'(n_loads - base), 72'd0);

      // Single word AA 55 0F F0, good trailer where enabled.
      do_reset();
      base = n_loads;
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_word(32'hAA55_0FF0, 0);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h00, 0);
`endif
      wait_end("one_end");
      check("one_done", {69'h0, o_done, o_cpu_hold, o_error}, {69'h0, 3'b100});
      if (n_loads - base == 1)
         check("one_write", {8'h0, mon_addr[base], mon_inst[base]}, {8'h0, 32'h0, 32'hAA55_0FF0});
      else
         check("one_nloads", 72'(n_loads - base), 72'd1);

`ifdef LOADER_CHECKSUM_EN
      // Bad trailer: word already written, then error.
      do_reset();
      base = n_loads;
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_word(32'hAA55_0FF0, 0);
      send_byte(8'h01, 0);
      @(negedge clk);
      check("csum_bad", {69'h0, o_error, o_cpu_hold, o_done}, {69'h0, 3'b110});
      check("csum_bad_loads", 72'(n_loads - base), 72'd1);
`endif

      // Reset mid-word, then a fresh image.
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      i_rst = 1'b1;
      @(negedge clk);
      check("rst_ready_low", {70'h0, o_in_ready, o_cpu_hold}, {70'h0, 2'b01});
      tick();
      i_rst = 1'b0;
      @(negedge clk);
      check("rst_values", {36'h0, o_in_ready, o_load, o_done, o_error, o_cpu_hold, o_load_addr},
            {36'h0, 5'b10001, 32'h0});
      tick();
      base = n_loads;
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_word(32'hDEAD_BEEF, 0);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h22, 0);
`endif
      wait_end("rst_end");
      check("rst_done", {70'h0, o_done, o_cpu_hold}, {70'h0, 2'b10});
      if (n_loads - base == 1)
         check("rst_write", {8'h0, mon_addr[base], mon_inst[base]}, {8'h0, 32'h0, 32'hDEAD_BEEF});
      else
         check("rst_nloads", 72'(n_loads - base), 72'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader feeding the instruction-fetch load port of the CPU core. Accepts a byte stream with a valid/ready handshake, parses a word-count header, assembles big-endian 32-bit instructions and writes them one per pulse to consecutive word addresses. Holds the core in reset until the image is complete. It is the transmitting end of the fetcher's `load` / `load_inst` interface.

## Interface
- `BASE_ADDR`, 32'h0000_0000, byte address of the first instruction written; word-aligned.
- `MAX_WORDS`, 1024, largest accepted word count; a larger header count is an error.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  byte on `in_data` is offered.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle; transfer = `in_valid && in_ready`.
- `load`  out  1  one-cycle write strobe to the fetcher.
- `load_addr`  out  32  byte address of `load_inst`; valid while `load`.
- `load_inst`  out  32  instruction word; valid while `load`.
- `cpu_hold`  out  1  drives the core's `rst`; high until load completes.
- `done`  out  1  image loaded successfully; sticky until `rst`.
- `error`  out  1  bad count or checksum; sticky until `rst`.

## Operation
- Stream format: count high byte, count low byte (16-bit word count N), N×4 payload bytes (MSB first per word), then one checksum byte when `LOADER_CHECKSUM_EN` is defined.
- States: HDR_HI → HDR_LO → WORD → WRITE → (WORD | CSUM | DONE); ERR terminal; DONE terminal.
- HDR_HI: accepted byte → count[15:8]. HDR_LO: accepted byte → count[7:0]; then N > MAX_WORDS → ERR; N = 0 → CSUM (if enabled) else DONE; otherwise WORD.
- WORD: 2-bit byte index 0..3; each accepted byte shifts into word register (first byte lands in [31:24]). After index 3 accepted → WRITE.
- WRITE: `load`=1, `load_addr`=current address, `load_inst`=assembled word; `in_ready`=0. Next edge: address += 4 (32-bit wrap, no check), remaining −1; remaining 0 → CSUM/DONE, else WORD.
- CSUM: accepted byte compared against running XOR of all payload bytes (header excluded); equal → DONE, else → ERR.
- DONE: `done`=1, `cpu_hold`=0, `in_ready`=0; further input ignored.
- ERR: `error`=1, `cpu_hold`=1, `in_ready`=0; recovery only via `rst`.
- `in_ready`=1 in HDR_HI, HDR_LO, WORD, CSUM; 0 elsewhere. `in_valid` without `in_ready` has no effect; no byte is lost or duplicated.

## Timing
- Reset values: state HDR_HI, `in_ready`=0 during `rst`, `load`=0, `load_addr`=BASE_ADDR, `load_inst`=0, `cpu_hold`=1, `done`=0, `error`=0, XOR=0, byte index 0.
- `in_ready` combinational from state only (never from `in_valid`).
- 4th byte of a word accepted at edge k → `load` high in cycle k+1, exactly one cycle.
- Full-rate stream: 5 cycles per word (4 accept + 1 WRITE).
- Final WRITE (or checksum accept) at edge k → `done` high and `cpu_hold` low from cycle k+1, same cycle.
- Bad count detected at the HDR_LO accept edge → `error` high next cycle; no `load` ever issued.
- `rst` mid-stream: state and all outputs return to reset values next edge; a partial word is discarded; `cpu_hold` stays high.

## Configuration
- `LOADER_CHECKSUM_EN` defined: CSUM state present, XOR accumulator maintained, mismatch → ERR.
- Undefined: no CSUM state or XOR register; last WRITE (or N=0 header) goes directly to DONE; `error` only from count overflow.

## Structure
- Package `LoaderType`: state enum `loader_state_t` (HDR_HI, HDR_LO, WORD, WRITE, CSUM, DONE, ERR), `word_count_t` (16 bit), shared `inst_t`/`addr_t` from `Types`.
- One sub-module natural: `WordAssembler` (byte shift register + 2-bit index, `full` flag, clear on `rst`).

## Test plan
- N=2, bytes 00 02 | 20 08 00 05 | 00 00 00 0C, full rate → `load` pulses with 0x0000_0000/0x2008_0005 then 0x0000_0004/0x0000_000C; `done` cycle after second pulse.
- Same stream with `in_valid` toggling every other cycle → identical writes, no duplicates, `in_ready` low only in WRITE.
- Header 04 01 with MAX_WORDS=1024 → `error`=1, `cpu_hold`=1, zero `load` pulses, `in_ready`=0 thereafter.
- Header 00 00 → no `load`; `done` after header (or after checksum 00 when enabled).
- Checksum enabled, N=1 word AA 55 0F F0, trailer 00 → DONE; trailer 01 → ERR with the word already written.
- `rst` after 2 payload bytes, then a fresh N=1 image → write goes to BASE_ADDR with only new bytes.
